// File: rtl/seven_seg_scan_driver_if.sv
// Bundle of the value/control inputs and the display outputs of the
// seven-segment scan driver. The master side loads values and watches BUSY;
// the slave side is the driver itself.
interface seven_seg_scan_driver_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]  i_bin;
  logic              i_load;
  logic              i_err;
  logic              i_lzb;
  logic              o_busy;
  logic [0:6]        o_sev;
  logic [DIGITS-1:0] o_an;

  modport master (
    output i_bin, i_load, i_err, i_lzb,
    input  o_busy, o_sev, o_an
  );

  modport slave (
    input  i_bin, i_load, i_err, i_lzb,
    output o_busy, o_sev, o_an
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed active-low seven-segment driver. A loaded binary value is
// converted to BCD one bit per clock (shift-and-add-3) and then committed in
// one step to the display register, which is scanned digit by digit onto a
// shared segment bus with leading-zero blanking and dash-on-error.
module seven_seg_scan_driver #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  seven_seg_scan_driver_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Largest value that fits in DIGITS decimal digits (10^DIGITS - 1).
  function automatic logic [63:0] max_display(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int k = 0; k < n; k++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_display(DIGITS);

  // Active-low a..g pattern for a BCD nibble; anything above 9 shows a dash.
  function automatic logic [0:6] seg_encode(input logic [3:0] nib);
    logic [0:6] seg;
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0001100;
      default: seg = 7'b1111110;
    endcase
    return seg;
  endfunction

  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t             r_state;
  logic               r_busy;
  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [BCD_W-1:0]   r_disp;
  logic               r_disp_err;
  logic [PRE_W-1:0]   r_presc;
  logic [IDX_W-1:0]   r_idx;
  logic [0:6]         r_sev;
  logic [DIGITS-1:0]  r_an;

  state_t             w_state_nxt;
  logic               w_capture;
  logic               w_step;
  logic               w_done;
  logic               w_bin_over;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic [3:0]         w_sel_nib;
  logic               w_upper_nz;
  logic [0:6]         w_sev_nxt;
  logic [DIGITS-1:0]  w_an_nxt;

  assign w_bin_over  = (64'(bus.i_bin) > MAX_VAL);
  assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_shift[WIDTH-1]};

  // Next-state and conversion control; LOAD is only honoured while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_load) begin
          w_capture   = 1'b1;
          w_state_nxt = CONV;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CONV: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = CONV;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with BUSY registered alongside it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == CONV);
    end
  end

  // Add-3 correction of every BCD nibble that is 5 or more before the shift.
  always_comb begin
    w_bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_bcd_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                      : r_bcd[4*d +: 4];
    end
  end

  // Conversion datapath; the display register only changes on the last step,
  // so a partially converted value is never visible.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_disp     <= '0;
      r_disp_err <= 1'b0;
    end else if (w_capture) begin
      r_shift <= bus.i_bin;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_err   <= bus.i_err | w_bin_over;
    end else if (w_step) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      r_bcd   <= w_bcd_shift;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_done) begin
        r_disp     <= w_bcd_shift;
        r_disp_err <= r_err;
      end
    end
  end

  // Refresh prescaler and digit index; the index steps once per prescaler wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRE_W'(REFRESH_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : (r_idx + IDX_W'(1));
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Pick the selected nibble, detect non-zero digits at or above it, and
  // build the next segment and anode patterns.
  always_comb begin
    w_sel_nib  = 4'd0;
    w_upper_nz = 1'b0;
    w_an_nxt   = '1;
    for (int d = 0; d < DIGITS; d++) begin
      w_sel_nib   = (IDX_W'(d) == r_idx) ? r_disp[4*d +: 4] : w_sel_nib;
      w_upper_nz  = w_upper_nz | ((IDX_W'(d) >= r_idx) && (r_disp[4*d +: 4] != 4'd0));
      w_an_nxt[d] = (IDX_W'(d) != r_idx);
    end
    if (r_disp_err) begin
      w_sev_nxt = SEG_DASH;
    end else if (bus.i_lzb && (r_idx != IDX_W'(0)) && !w_upper_nz) begin
      w_sev_nxt = SEG_BLANK;
    end else begin
      w_sev_nxt = seg_encode(w_sel_nib);
    end
  end

  // Registered display pins; anodes and segments always move together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sev <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_sev <= w_sev_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_sev  = r_sev;
  assign bus.o_an   = r_an;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (WIDTH=10, DIGITS=3,
// REFRESH_DIV=4) with hand-computed segment/anode expectations.
module tb_seven_seg_scan_driver;

  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S1    = 7'b1001111;
  localparam logic [6:0] S2    = 7'b0010010;
  localparam logic [6:0] S3    = 7'b0000110;
  localparam logic [6:0] S4    = 7'b1001100;
  localparam logic [6:0] S5    = 7'b0100100;
  localparam logic [6:0] S7    = 7'b0001111;
  localparam logic [6:0] SDASH = 7'b1111110;
  localparam logic [6:0] SBLNK = 7'b1111111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seven_seg_scan_driver_if #(.WIDTH(10), .DIGITS(3)) bus_if ();

  seven_seg_scan_driver #(
    .WIDTH(10), .DIGITS(3), .REFRESH_DIV(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Wait for the anodes to move onto pattern pat (leaves current pattern first).
  task automatic wait_an(input logic [2:0] pat);
    int n;
    n = 0;
    while (bus_if.o_an == pat && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus_if.o_an != pat && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_digit(input string tag, input logic [2:0] pat, input logic [6:0] exp);
    wait_an(pat);
    check({tag, "_an"}, 32'(bus_if.o_an), 32'(pat));
    check({tag, "_sev"}, 32'(bus_if.o_sev), 32'(exp));
  endtask

  task automatic do_load(input logic [9:0] val, input logic e);
    int n;
    bus_if.i_bin  = val;
    bus_if.i_err  = e;
    bus_if.i_load = 1'b1;
    @(negedge clk);
    bus_if.i_load = 1'b0;
    bus_if.i_err  = 1'b0;
    n = 0;
    while (bus_if.o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("load_done", 32'(bus_if.o_busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int hb;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus_if.i_bin  = '0;
    bus_if.i_load = 1'b0;
    bus_if.i_err  = 1'b0;
    bus_if.i_lzb  = 1'b1;

    // Reset held for 3 clocks.
    repeat (3) @(negedge clk);
    check("rst_sev",  32'(bus_if.o_sev),  32'(SBLNK));
    check("rst_an",   32'(bus_if.o_an),   32'b111);
    check("rst_busy", 32'(bus_if.o_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_an",  32'(bus_if.o_an),  32'b110);
    check("rel_sev", 32'(bus_if.o_sev), 32'(S0));
    repeat (3) @(negedge clk);
    check("hold_an", 32'(bus_if.o_an), 32'b110);
    @(negedge clk);
    check("step_an",  32'(bus_if.o_an),  32'b101);
    check("step_sev", 32'(bus_if.o_sev), 32'(SBLNK));

    // Conversion of 123: BUSY high for exactly WIDTH=10 clocks.
    bus_if.i_bin  = 10'd123;
    bus_if.i_load = 1'b1;
    @(negedge clk);
    bus_if.i_load = 1'b0;
    cnt = 0;
    while (bus_if.o_busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_len_123", 32'(cnt), 32'd10);
    check_digit("d0_123", 3'b110, S3);
    check_digit("d1_123", 3'b101, S2);
    check_digit("d2_123", 3'b011, S1);
    wait_an(3'b011);
    while (bus_if.o_an == 3'b011 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("wrap_an", 32'(bus_if.o_an), 32'b110);

    // Leading-zero blanking of 7, then live LZB toggle.
    do_load(10'd7, 1'b0);
    check_digit("d0_7", 3'b110, S7);
    check_digit("d1_7_lzb", 3'b101, SBLNK);
    check_digit("d2_7_lzb", 3'b011, SBLNK);
    wait_an(3'b101);
    check("d1_7_pre", 32'(bus_if.o_sev), 32'(SBLNK));
    bus_if.i_lzb = 1'b0;
    @(negedge clk);
    check("d1_7_nolzb_an",  32'(bus_if.o_an),  32'b101);
    check("d1_7_nolzb_sev", 32'(bus_if.o_sev), 32'(S0));
    check_digit("d2_7_nolzb", 3'b011, S0);
    bus_if.i_lzb = 1'b1;

    // Overflow and error.
    do_load(10'd1000, 1'b0);
    check_digit("d0_ovf", 3'b110, SDASH);
    check_digit("d1_ovf", 3'b101, SDASH);
    check_digit("d2_ovf", 3'b011, SDASH);
    do_load(10'd5, 1'b1);
    check_digit("d0_err", 3'b110, SDASH);
    check_digit("d2_err", 3'b011, SDASH);
    do_load(10'd5, 1'b0);
    check_digit("d0_5", 3'b110, S5);
    check_digit("d1_5", 3'b101, SBLNK);

    // LOAD during conversion is ignored.
    bus_if.i_bin  = 10'd45;
    bus_if.i_load = 1'b1;
    @(negedge clk);
    bus_if.i_load = 1'b0;
    cnt = 0;
    while (bus_if.o_busy && cnt < 50) begin
      cnt++;
      if (cnt == 3) begin
        bus_if.i_bin  = 10'd99;
        bus_if.i_load = 1'b1;
      end else begin
        bus_if.i_load = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.i_load = 1'b0;
    check("busy_len_45", 32'(cnt), 32'd10);
    @(negedge clk);
    check("no_requeue", 32'(bus_if.o_busy), 32'd0);
    check_digit("d0_45", 3'b110, S5);
    check_digit("d1_45", 3'b101, S4);
    check_digit("d2_45", 3'b011, SBLNK);

    // Reset mid-conversion aborts it and clears the display.
    bus_if.i_bin  = 10'd123;
    bus_if.i_load = 1'b1;
    @(negedge clk);
    bus_if.i_load = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 32'(bus_if.o_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus_if.o_busy), 32'd0);
    check("abort_an",   32'(bus_if.o_an),   32'b111);
    check("abort_sev",  32'(bus_if.o_sev),  32'(SBLNK));
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_an",  32'(bus_if.o_an),  32'b110);
    check("abort_rel_sev", 32'(bus_if.o_sev), 32'(S0));
    hb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hb = hb + ((bus_if.o_busy === 1'b1) ? 1 : 0);
    end
    check("abort_no_busy", 32'(hb), 32'd0);
    check_digit("d0_abort", 3'b110, S0);
    check_digit("d1_abort", 3'b101, SBLNK);
    check_digit("d2_abort", 3'b011, SBLNK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
